wb_slave_standard_wrapper: RTL and testbench
============================================

Name: wb_slave_standard_wrapper

Overview:
- Wishbone B4 pipelined-mode slave front end wrapped around a standard-mode (classic) register-file slave core.
- Accepts single and back-to-back pipelined requests from a pipelined master.
- Throttles the master with stall so that the standard core sees one transfer at a time.
- Sits on the system Wishbone bus as a simple memory-mapped word store.

Parameters:
- adr_width, 16, address bus width in bits.
- dat_width, 16, data bus width in bits.
- mem_depth, 32, number of dat_width-bit storage words; must be a power of two and ≤ 2**adr_width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- adr  in  adr_width  word address from master.
- dat_m  in  dat_width  write data, master to slave.
- dat_s  out  dat_width  read data, slave to master.
- we  in  1  1 = write, 0 = read.
- cyc  in  1  bus cycle valid.
- stb  in  1  request strobe.
- ack  out  1  transfer acknowledge.
- stall  out  1  slave cannot accept a request this cycle.
- err  out  1  error acknowledge; tied 0 unless WB_ERR_EN is defined.

Behaviour:
- Reset (rst_n=0 at a clk edge): ack=0, err=0, stall=0, dat_s=0; any pending transfer is discarded. Storage contents are not reset.
- Request acceptance: a request is accepted at a rising edge when cyc=1, stb=1 and stall=0.
- Accept edge actions:
  - Write: mem[adr mod mem_depth] <= dat_m.
  - Read: dat_s <= mem[adr mod mem_depth].
  - Pending-ack flag is set.
- Ack cycle (the cycle after acceptance):
  - ack=1 for exactly one cycle.
  - stall=1 in this same cycle; stall equals the pending flag, registered.
  - dat_s holds the read data during ack and keeps its value until the next read.
- Latency and throughput:
  - Latency is 1 cycle from accept edge to ack.
  - Maximum throughput is one transfer per 2 cycles.
  - With stb held high, transfers are accepted on every other edge.
- No write occurs while stall=1; the master must hold adr, dat_m and we stable until accepted.
- Idle: stb=0 or cyc=0 gives ack=0 and stall=0.
- cyc deasserted during the ack cycle: ack and err are gated by cyc and output 0. A write already performed stays committed; the pending flag still clears.
- stb low with cyc high: no request; existing ack still completes.
- Address wrap: adr ≥ mem_depth aliases to adr mod mem_depth (low bits) when WB_ERR_EN is not defined.
- Reset asserted mid-transfer: ack and stall are 0 from the next edge. A write committed before reset is retained.
- Back-to-back write then read of the same address: the read returns the newly written data.

Optional Feature:
- Macro WB_ERR_EN.
- Defined:
  - An accepted request with adr ≥ mem_depth performs no storage access.
  - err=1 and ack=0 in the response cycle.
  - stall timing is identical to a normal transfer.
  - dat_s is unchanged.
- Not defined:
  - err is constant 0.
  - Out-of-range addresses wrap as above and are acknowledged normally.

Test Plan:
1. Reset held 3 cycles, then released → ack=0, stall=0, err=0, dat_s=0 throughout reset and after release.
2. Ten isolated single writes, adr=i, dat_m=100+i for i=1..10, cyc/stb dropped after each ack → each ack one cycle after accept, stall=1 only in the ack cycle.
3. Ten isolated single reads, adr=1..10 → dat_s=101..110 during the respective ack.
4. Pipelined burst: stb held high, adr=11..20, dat_m=211..220, then stb=0 and cyc=0 → exactly 10 acks, one per 2 cycles. stall alternates, no lost or duplicated write.
5. Pipelined burst read, adr=11..20 → dat_s=211..220 in order, 10 acks.
6. cyc dropped in the ack cycle of a write to adr=5 → ack=0; a subsequent read of adr 5 returns the new data. With WB_ERR_EN, a read of adr=40 → err=1, ack=0; without it, adr=40 returns mem[8].

Source files
------------

// File: rtl/wb_slave_standard_wrapper_if.sv
// -----------------------------------------------------------------------------
// wb_slave_standard_wrapper_if
// Wishbone B4 pipelined-mode bus bundle between one master and one slave.
//
// Signals:
//   adr    master -> slave   word address
//   dat_m  master -> slave   write data
//   dat_s  slave  -> master  read data
//   we     master -> slave   1 = write, 0 = read
//   cyc    master -> slave   bus cycle valid
//   stb    master -> slave   request strobe
//   ack    slave  -> master  transfer acknowledge
//   stall  slave  -> master  slave cannot accept a request this cycle
//   err    slave  -> master  error acknowledge
// -----------------------------------------------------------------------------
interface wb_slave_standard_wrapper_if #(
    parameter int adr_width = 16,
    parameter int dat_width = 16
);
    logic [adr_width-1:0] adr;
    logic [dat_width-1:0] dat_m;
    logic [dat_width-1:0] dat_s;
    logic                 we;
    logic                 cyc;
    logic                 stb;
    logic                 ack;
    logic                 stall;
    logic                 err;

    modport master (
        output adr, dat_m, we, cyc, stb,
        input  dat_s, ack, stall, err
    );

    modport slave (
        input  adr, dat_m, we, cyc, stb,
        output dat_s, ack, stall, err
    );
endinterface

// File: rtl/wb_slave_standard_wrapper.sv
// -----------------------------------------------------------------------------
// wb_slave_standard_wrapper
// Wishbone B4 pipelined-mode slave front end around a classic single-transfer
// word store. Every accepted request is answered exactly one cycle later, and
// stall is raised in that response cycle so the store only ever sees one
// transfer at a time (max one transfer per two cycles).
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   bus    wb_slave_standard_wrapper_if.slave
//          (adr, dat_m, we, cyc, stb in; dat_s, ack, stall, err out)
//
// Configuration macro:
//   WB_ERR_EN  when defined, an accepted request with adr >= mem_depth makes no
//              storage access and is answered with err instead of ack.
//              When undefined, err is constant 0 and out-of-range addresses
//              alias onto the low address bits.
// -----------------------------------------------------------------------------
module wb_slave_standard_wrapper #(
    parameter int adr_width = 16,
    parameter int dat_width = 16,
    parameter int mem_depth = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    wb_slave_standard_wrapper_if.slave        bus
);

    // Index width into the store; at least one bit so slices stay legal.
    localparam int idx_w = (mem_depth > 1) ? $clog2(mem_depth) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t               state_r;
    logic                 ack_r;
    logic                 err_r;
    logic                 stall_r;
    logic [dat_width-1:0] dat_s_r;
    logic [dat_width-1:0] mem_r [mem_depth];

    logic                 accept_s;
    logic                 oor_s;
    logic [idx_w-1:0]     idx_s;

`ifdef WB_ERR_EN
    // True when any address bit at or above the index width is set,
    // i.e. the address lies outside the word store.
    function automatic logic adr_out_of_range(input logic [adr_width-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = idx_w; i < adr_width; i++) begin
            hit = hit | a[i];
        end
        return hit;
    endfunction
`endif

    // Request decode: accept only when the slave is not stalling.
    always_comb begin
        accept_s = 1'b0;
        idx_s    = bus.adr[idx_w-1:0];
`ifdef WB_ERR_EN
        oor_s    = adr_out_of_range(bus.adr);
`else
        oor_s    = 1'b0;
`endif
        if (bus.cyc && bus.stb && !stall_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Handshake FSM: accept in IDLE, answer (and stall) for one cycle in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            stall_r <= 1'b0;
            dat_s_r <= {dat_width{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_RESP;
                        stall_r <= 1'b1;
                        ack_r   <= !oor_s;
                        err_r   <= oor_s;
                        // Read data is captured on the accept edge and then
                        // held until the next successful read.
                        if (!bus.we && !oor_s) begin
                            dat_s_r <= mem_r[idx_s];
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        stall_r <= 1'b0;
                        ack_r   <= 1'b0;
                        err_r   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    // Pending flag clears even if the master dropped cyc.
                    state_r <= ST_IDLE;
                    stall_r <= 1'b0;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    stall_r <= 1'b0;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    // Word store write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept_s && bus.we && !oor_s) begin
            mem_r[idx_s] <= bus.dat_m;
        end
    end

    // ack/err are qualified by cyc so an abandoned cycle sees no response.
    assign bus.ack   = ack_r & bus.cyc;
    assign bus.err   = err_r & bus.cyc;
    assign bus.stall = stall_r;
    assign bus.dat_s = dat_s_r;

endmodule

// File: tb/tb_wb_slave_standard_wrapper.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_standard_wrapper
// Directed-vector bench for wb_slave_standard_wrapper. Inputs are driven and
// outputs sampled on the falling clock edge; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_wb_slave_standard_wrapper;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n_ack;

    wb_slave_standard_wrapper_if #(.adr_width(16), .dat_width(16)) bus ();

    wb_slave_standard_wrapper #(
        .adr_width(16),
        .dat_width(16),
        .mem_depth(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison, report it if observed differs from expected.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer: present the request, check the response cycle.
    // hold=1 keeps cyc/stb high afterwards (pipelined burst).
    task automatic wb_xfer(input string tag, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] exp_d,
                           input logic exp_err, input logic hold);
        @(negedge clk);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = w;
        bus.adr   = a;
        bus.dat_m = d;
        check_eq({tag, "_req_stall"}, 32'(bus.stall), 32'd0);
        check_eq({tag, "_req_ack"},   32'(bus.ack),   32'd0);
        @(negedge clk);
        if (bus.ack === 1'b1) n_ack++;
        check_eq({tag, "_ack"},   32'(bus.ack),   exp_err ? 32'd0 : 32'd1);
        check_eq({tag, "_err"},   32'(bus.err),   exp_err ? 32'd1 : 32'd0);
        check_eq({tag, "_stall"}, 32'(bus.stall), 32'd1);
        if (!w) check_eq({tag, "_dat"}, 32'(bus.dat_s), 32'(exp_d));
        if (!hold) begin
            bus.cyc = 1'b0;
            bus.stb = 1'b0;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        n_ack     = 0;
        rst_n     = 1'b0;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.adr   = 16'd0;
        bus.dat_m = 16'd0;

        // 1. reset held three cycles, then released
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_ack",   32'(bus.ack),   32'd0);
            check_eq("rst_stall", 32'(bus.stall), 32'd0);
            check_eq("rst_err",   32'(bus.err),   32'd0);
            check_eq("rst_dat",   32'(bus.dat_s), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ack",   32'(bus.ack),   32'd0);
        check_eq("post_rst_stall", 32'(bus.stall), 32'd0);
        check_eq("post_rst_dat",   32'(bus.dat_s), 32'd0);

        // 2. isolated writes adr=1..10, data 101..110
        for (int i = 1; i <= 10; i++)
            wb_xfer("swr", 1'b1, 16'(i), 16'(100 + i), 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("idle_stall", 32'(bus.stall), 32'd0);
        check_eq("idle_ack",   32'(bus.ack),   32'd0);

        // 3. isolated reads
        for (int i = 1; i <= 10; i++)
            wb_xfer("srd", 1'b0, 16'(i), 16'd0, 16'(100 + i), 1'b0, 1'b0);

        // 4. pipelined burst write with stb held high
        n_ack = 0;
        for (int i = 11; i <= 20; i++)
            wb_xfer("bwr", 1'b1, 16'(i), 16'(200 + i), 16'd0, 1'b0, 1'b1);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        check_eq("bwr_nack", 32'(n_ack), 32'd10);

        // 5. pipelined burst read
        n_ack = 0;
        for (int i = 11; i <= 20; i++)
            wb_xfer("brd", 1'b0, 16'(i), 16'd0, 16'(200 + i), 1'b0, 1'b1);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        check_eq("brd_nack", 32'(n_ack), 32'd10);

        // 6. cyc dropped in the ack cycle of a write to adr 5
        @(negedge clk);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.adr   = 16'd5;
        bus.dat_m = 16'h0555;
        @(negedge clk);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        #1;
        check_eq("cycdrop_ack",   32'(bus.ack),   32'd0);
        check_eq("cycdrop_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        check_eq("cycdrop_clear", 32'(bus.stall), 32'd0);
        wb_xfer("rd5", 1'b0, 16'd5, 16'd0, 16'h0555, 1'b0, 1'b0);
`ifdef WB_ERR_EN
        wb_xfer("rd40", 1'b0, 16'd40, 16'd0, 16'h0555, 1'b1, 1'b0);
`else
        wb_xfer("rd40", 1'b0, 16'd40, 16'd0, 16'd108, 1'b0, 1'b0);
`endif

        // back-to-back write then read of the same address
        wb_xfer("b2b_wr", 1'b1, 16'd9, 16'h0999, 16'd0, 1'b0, 1'b1);
        wb_xfer("b2b_rd", 1'b0, 16'd9, 16'd0, 16'h0999, 1'b0, 1'b0);

        // stb dropped with cyc high: pending ack still completes
        @(negedge clk);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.adr   = 16'd6;
        bus.dat_m = 16'h0666;
        @(negedge clk);
        check_eq("stblow_ack", 32'(bus.ack), 32'd1);
        bus.stb = 1'b0;
        @(negedge clk);
        check_eq("stblow_idle_ack",   32'(bus.ack),   32'd0);
        check_eq("stblow_idle_stall", 32'(bus.stall), 32'd0);
        bus.cyc = 1'b0;

        // reset asserted in the ack cycle of a write to adr 7
        @(negedge clk);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.adr   = 16'd7;
        bus.dat_m = 16'h0777;
        @(negedge clk);
        check_eq("midrst_ack", 32'(bus.ack), 32'd1);
        bus.stb = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check_eq("midrst_ack0",   32'(bus.ack),   32'd0);
        check_eq("midrst_stall0", 32'(bus.stall), 32'd0);
        check_eq("midrst_dat0",   32'(bus.dat_s), 32'd0);
        rst_n   = 1'b1;
        bus.cyc = 1'b0;
        wb_xfer("rd7", 1'b0, 16'd7, 16'd0, 16'h0777, 1'b0, 1'b0);
        wb_xfer("rd6", 1'b0, 16'd6, 16'd0, 16'h0666, 1'b0, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
